core_cdiv: RTL

- Iterative RV32M divide/remainder controller for the execute stage of the RV32I pipeline. It sits beside the single-cycle ALU.
- It accepts DIV/DIVU/REM/REMU operations and sequences a 1-bit-per-cycle restoring divider.
- It raises a stall to the hazard unit while an operation is outstanding and returns a result through a valid/ready handshake.

---
 rtl/core_cdiv_pkg.sv | 16 +
 rtl/core_div_iter.sv | 57 +++++
 rtl/core_cdiv.sv | 107 ++++++++++
 3 files changed

// File: rtl/core_cdiv_pkg.sv
// Shared constants and state encoding for the RV32M divide/remainder unit.
package core_cdiv_pkg;

    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/core_div_iter.sv
// Restoring divider datapath: one quotient bit per step, down-counter with
// terminal-count flag on the final iteration.
module core_div_iter
    import core_cdiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo,
    output logic [XLEN-1:0] o_rem,
    output logic            o_last
);

    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_div;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN:0]    w_shift;
    logic             w_ge;
    logic [XLEN-1:0]  w_sub;

    // Shifted partial remainder needs one extra bit; when it overflows XLEN
    // bits the difference still fits, so the low-bit subtract is exact.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[XLEN-1:0] - r_div;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
            r_cnt <= CNT_W'(XLEN);
        end else if (i_step && (r_cnt != '0)) begin
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_quo  = r_quo;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/core_cdiv.sv
// Iterative DIV/DIVU/REM/REMU controller: handshakes, special cases, sign fix-up.
//   state | meaning
//   IDLE  | ready for a new op
//   BUSY  | datapath iterating, pipeline stalled
//   DONE  | result presented until writeback takes it
module core_cdiv
    import core_cdiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic            VALID_IN,
    output logic            READY_IN,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OP_A,
    input  logic [XLEN-1:0] OP_B,
    input  logic            FLUSH,
    output logic            VALID_OUT,
    input  logic            READY_OUT,
    output logic [XLEN-1:0] RESULT,
    output logic            STALL
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      r_state, w_state_nxt;
    logic            r_neg_q, r_neg_r, r_sel_rem, r_special;
    logic [XLEN-1:0] r_spec_res;

    logic            w_signed, w_fire, w_div_zero, w_ovf, w_special;
    logic            w_last, w_start, w_step;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_quo, w_rem, w_q_fix, w_r_fix, w_res;

    assign w_signed   = !FUNCT3[0];
    assign READY_IN   = (r_state == DIV_ST_IDLE);
    assign w_fire     = VALID_IN && READY_IN && FUNCT3[2] && !FLUSH;
    assign w_div_zero = (OP_B == '0);
    assign w_ovf      = w_signed && (OP_A == MIN_NEG) && (OP_B == '1);
    assign w_special  = w_div_zero || w_ovf;

    assign w_abs_a = (w_signed && OP_A[XLEN-1]) ? -OP_A : OP_A;
    assign w_abs_b = (w_signed && OP_B[XLEN-1]) ? -OP_B : OP_B;

    assign w_start = w_fire && !w_special;
    assign w_step  = (r_state == DIV_ST_BUSY);

    core_div_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_iter (
        .CLK        (CLK),
        .NRST       (NRST),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quo      (w_quo),
        .o_rem      (w_rem),
        .o_last     (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_ST_IDLE: if (w_fire) w_state_nxt = w_special ? DIV_ST_DONE : DIV_ST_BUSY;
            DIV_ST_BUSY: if (w_last) w_state_nxt = DIV_ST_DONE;
            DIV_ST_DONE: if (READY_OUT) w_state_nxt = DIV_ST_IDLE;
            default:     w_state_nxt = DIV_ST_IDLE;
        endcase
        if (FLUSH) w_state_nxt = DIV_ST_IDLE;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state    <= DIV_ST_IDLE;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_sel_rem  <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_neg_q   <= w_signed && (OP_A[XLEN-1] ^ OP_B[XLEN-1]);
                r_neg_r   <= w_signed && OP_A[XLEN-1];
                r_sel_rem <= FUNCT3[1];
                r_special <= w_special;
                // Special-case results bypass sign correction entirely.
                if (w_div_zero) r_spec_res <= FUNCT3[1] ? OP_A : '1;
                else            r_spec_res <= FUNCT3[1] ? '0 : MIN_NEG;
            end
        end
    end

    assign w_q_fix = r_neg_q ? -w_quo : w_quo;
    assign w_r_fix = r_neg_r ? -w_rem : w_rem;
    assign w_res   = r_special ? r_spec_res : (r_sel_rem ? w_r_fix : w_q_fix);

    assign VALID_OUT = (r_state == DIV_ST_DONE) && !FLUSH;
    assign RESULT    = VALID_OUT ? w_res : '0;
    assign STALL     = (r_state == DIV_ST_BUSY)
                     || ((r_state == DIV_ST_DONE) && !READY_OUT)
                     || w_fire;

endmodule
